// File: rtl/fetch_stage64_pkg.sv
// Shared types and constants for the fetch_stage64 instruction fetch front end.
package fetch_stage64_pkg;

    localparam int unsigned FETCH_XLEN = 64;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 64'h0;

    // One fetched instruction as handed to decode.
    typedef struct packed {
        logic [31:0]           instruction;
        logic [FETCH_XLEN-1:0] pc;
        logic                  nlp_hit;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; used for both the in-flight
// metadata queue and the decode-facing output buffer.
module fetch_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [Width-1:0]       push_data,
    input  logic                   pop,
    output logic [Width-1:0]       pop_data,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(Depth));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so push is legal when full and popping.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage64.sv
// Instruction fetch front end: issues in-order imem requests from a sequential or
// NLP-predicted PC, buffers returned words and presents them to decode.
module fetch_stage64
    import fetch_stage64_pkg::*;
#(
    parameter int unsigned     XLEN       = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic            fetch_request_valid_o,
    input  logic            fetch_request_ready_i,
    output logic [XLEN-1:0] fetch_request_PC_o,
    input  logic            imem_response_valid_i,
    input  logic [31:0]     imem_response_instruction_i,
    input  logic            nlp_hit_i,
    input  logic [XLEN-1:0] nlp_target_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_PC_i,
    output logic            fetch_response_valid_o,
    input  logic            fetch_response_ready_i,
    output logic [31:0]     fetch_response_instruction_o,
    output logic [XLEN-1:0] fetch_response_PC_o,
    output logic            fetch_NLP_BTB_hit_o
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned MetaW = XLEN + 1;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CntW-1:0]  outstanding_q, outstanding_d;
    logic [CntW-1:0]  drop_q, drop_d;
    logic [CntW:0]    in_use;

    logic             req_fire;
    logic             resp_live;
    logic             resp_drop;
    logic             resp_accept;
    logic             dec_pop;

    logic [MetaW-1:0] meta_head;
    logic [CntW-1:0]  meta_count;
    logic             meta_full, meta_empty;

    fetch_entry_t     out_push_entry;
    fetch_entry_t     out_head;
    logic [CntW-1:0]  out_count;
    logic             out_full, out_empty;

    // Credits cover both in-flight (including to-be-dropped) and buffered words.
    assign in_use = (CntW+1)'(outstanding_q) + (CntW+1)'(out_count);

    assign fetch_request_valid_o = reset && !redirect_valid_i &&
                                   (in_use < (CntW+1)'(FIFO_DEPTH));
    assign fetch_request_PC_o    = pc_q;
    assign req_fire              = fetch_request_valid_o && fetch_request_ready_i;

    assign resp_live   = imem_response_valid_i && (outstanding_q != '0);
    assign resp_drop   = resp_live && (drop_q != '0);
    assign resp_accept = resp_live && (drop_q == '0);

    assign fetch_response_valid_o       = !out_empty;
    assign fetch_response_instruction_o = out_head.instruction;
    assign fetch_response_PC_o          = out_head.pc;
    assign fetch_NLP_BTB_hit_o          = out_head.nlp_hit;
    assign dec_pop = fetch_response_valid_o && fetch_response_ready_i;

    always_comb begin
        out_push_entry.instruction = imem_response_instruction_i;
        out_push_entry.pc          = meta_head[MetaW-1:1];
        out_push_entry.nlp_hit     = meta_head[0];
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(resp_live);
        drop_d        = drop_q;
        if (req_fire) begin
            pc_d = nlp_hit_i ? nlp_target_i : pc_q + XLEN'(INSTR_BYTES);
        end
        if (redirect_valid_i) begin
            pc_d   = redirect_PC_i;
            // Everything still in flight after this cycle's return is stale.
            drop_d = outstanding_q - CntW'(resp_live);
        end else if (resp_drop) begin
            drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .Width (MetaW),
        .Depth (FIFO_DEPTH)
    ) u_meta_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid_i),
        .push      (req_fire),
        .push_data ({pc_q, nlp_hit_i}),
        .pop       (resp_accept),
        .pop_data  (meta_head),
        .count     (meta_count),
        .full      (meta_full),
        .empty     (meta_empty)
    );

    // Flush beats a same-cycle decode pop, so a redirect loses that handshake.
    fetch_fifo #(
        .Width ($bits(fetch_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid_i),
        .push      (resp_accept),
        .push_data (out_push_entry),
        .pop       (dec_pop),
        .pop_data  (out_head),
        .count     (out_count),
        .full      (out_full),
        .empty     (out_empty)
    );

    logic unused_status;
    assign unused_status = ^{meta_count, meta_full, meta_empty, out_full};

endmodule

// File: tb/tb_fetch_stage64.sv
// Directed self-checking bench for fetch_stage64; memory returns PC[31:0]+0x13.
module tb_fetch_stage64;
    import fetch_stage64_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_request_valid_o;
    logic        fetch_request_ready_i = 1'b0;
    logic [63:0] fetch_request_PC_o;
    logic        imem_response_valid_i = 1'b0;
    logic [31:0] imem_response_instruction_i = '0;
    logic        nlp_hit_i = 1'b0;
    logic [63:0] nlp_target_i = '0;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_PC_i = '0;
    logic        fetch_response_valid_o;
    logic        fetch_response_ready_i = 1'b0;
    logic [31:0] fetch_response_instruction_o;
    logic [63:0] fetch_response_PC_o;
    logic        fetch_NLP_BTB_hit_o;

    int compared = 0;
    int mismatched = 0;
    bit mem_en = 1'b1;

    logic [63:0]  pend_q[$];
    logic [63:0]  req_log[$];
    fetch_entry_t dec_q[$];

    fetch_stage64 dut (
        .clock                        (clock),
        .reset                        (reset),
        .fetch_request_valid_o        (fetch_request_valid_o),
        .fetch_request_ready_i        (fetch_request_ready_i),
        .fetch_request_PC_o           (fetch_request_PC_o),
        .imem_response_valid_i        (imem_response_valid_i),
        .imem_response_instruction_i  (imem_response_instruction_i),
        .nlp_hit_i                    (nlp_hit_i),
        .nlp_target_i                 (nlp_target_i),
        .redirect_valid_i             (redirect_valid_i),
        .redirect_PC_i                (redirect_PC_i),
        .fetch_response_valid_o       (fetch_response_valid_o),
        .fetch_response_ready_i       (fetch_response_ready_i),
        .fetch_response_instruction_o (fetch_response_instruction_o),
        .fetch_response_PC_o          (fetch_response_PC_o),
        .fetch_NLP_BTB_hit_o          (fetch_NLP_BTB_hit_o)
    );

    always #5 clock = ~clock;

    // Memory model and decode monitor: one response per cycle, one cycle after request.
    initial begin
        logic [63:0]  rpc;
        fetch_entry_t e;
        forever begin
            @(negedge clock);
            if (fetch_request_valid_o === 1'b1 && fetch_request_ready_i) begin
                pend_q.push_back(fetch_request_PC_o);
                req_log.push_back(fetch_request_PC_o);
            end
            if (reset && fetch_response_valid_o === 1'b1 && fetch_response_ready_i &&
                !redirect_valid_i) begin
                e.instruction = fetch_response_instruction_o;
                e.pc          = fetch_response_PC_o;
                e.nlp_hit     = fetch_NLP_BTB_hit_o;
                dec_q.push_back(e);
            end
            @(posedge clock);
            #1;
            if (mem_en && pend_q.size() > 0) begin
                rpc = pend_q.pop_front();
                imem_response_valid_i = 1'b1;
                imem_response_instruction_i = rpc[31:0] + 32'h13;
            end else begin
                imem_response_valid_i = 1'b0;
            end
        end
    end

    task automatic apply_reset;
        reset = 1'b0;
        fetch_request_ready_i = 1'b0;
        fetch_response_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        nlp_hit_i = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        pend_q.delete();
        req_log.delete();
        dec_q.delete();
        mem_en = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        fetch_request_ready_i = 1'b1;
        fetch_response_ready_i = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        compared++;
        if (fetch_request_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_req_valid: got %b want 0", fetch_request_valid_o);
        end
        compared++;
        if (fetch_response_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_resp_valid: got %b want 0", fetch_response_valid_o);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        compared++;
        if (fetch_request_valid_o !== 1'b1) begin
            mismatched++; $display("FAIL first_req_valid: got %b want 1", fetch_request_valid_o);
        end
        compared++;
        if (fetch_request_PC_o !== 64'h0) begin
            mismatched++; $display("FAIL first_req_pc: got %h want 0", fetch_request_PC_o);
        end
        @(posedge clock);
        #1;
        fetch_request_ready_i = 1'b0;
        @(negedge clock);
        compared++;
        if (fetch_response_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL no_bypass: got %b want 0", fetch_response_valid_o);
        end
        compared++;
        if (fetch_request_PC_o !== 64'h4) begin
            mismatched++; $display("FAIL pc_after_first: got %h want 4", fetch_request_PC_o);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        compared++;
        if (fetch_response_valid_o !== 1'b1) begin
            mismatched++; $display("FAIL first_resp_valid: got %b want 1", fetch_response_valid_o);
        end
        compared++;
        if (fetch_response_instruction_o !== 32'h0000_0013) begin
            mismatched++;
            $display("FAIL first_resp_instr: got %h want 00000013", fetch_response_instruction_o);
        end
        compared++;
        if (fetch_response_PC_o !== 64'h0 || fetch_NLP_BTB_hit_o !== 1'b0) begin
            mismatched++;
            $display("FAIL first_resp_pc_hit: got %h/%b want 0/0", fetch_response_PC_o,
                     fetch_NLP_BTB_hit_o);
        end
        @(posedge clock);
        #1;
        fetch_response_ready_i = 1'b1;
        @(posedge clock);
        #1;
        fetch_response_ready_i = 1'b0;
    endtask

    task automatic test_sequential;
        fetch_entry_t e;
        apply_reset();
        fetch_request_ready_i = 1'b1;
        fetch_response_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            compared++;
            if (fetch_request_valid_o !== 1'b1 || fetch_request_PC_o !== 64'(4 * i)) begin
                mismatched++;
                $display("FAIL seq_req: got %b/%h want 1/%h", fetch_request_valid_o,
                         fetch_request_PC_o, 64'(4 * i));
            end
            if (i >= 2) begin
                compared++;
                if (fetch_response_valid_o !== 1'b1 ||
                    fetch_response_PC_o !== 64'(4 * (i - 2))) begin
                    mismatched++;
                    $display("FAIL seq_no_bubble: got %b/%h want 1/%h", fetch_response_valid_o,
                             fetch_response_PC_o, 64'(4 * (i - 2)));
                end
            end
        end
        @(posedge clock);
        #1;
        fetch_request_ready_i = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        compared++;
        if (dec_q.size() != 8) begin
            mismatched++; $display("FAIL seq_count: got %0d want 8", dec_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                e = dec_q[k];
                compared++;
                if (e.pc !== 64'(4 * k) || e.instruction !== 32'(4 * k + 'h13) ||
                    e.nlp_hit !== 1'b0) begin
                    mismatched++;
                    $display("FAIL seq_order[%0d]: got %h/%h/%b want %h/%h/0", k, e.pc,
                             e.instruction, e.nlp_hit, 64'(4 * k), 32'(4 * k + 'h13));
                end
            end
        end
    endtask

    task automatic test_nlp_hit;
        apply_reset();
        fetch_request_ready_i = 1'b1;
        fetch_response_ready_i = 1'b1;
        nlp_target_i = 64'h100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 3) begin
                compared++;
                if (fetch_request_PC_o !== 64'h100) begin
                    mismatched++; $display("FAIL nlp_target_pc: got %h want 100", fetch_request_PC_o);
                end
            end
            if (i == 4) begin
                compared++;
                if (fetch_response_PC_o !== 64'h8 || fetch_NLP_BTB_hit_o !== 1'b1 ||
                    fetch_response_instruction_o !== 32'h1B) begin
                    mismatched++;
                    $display("FAIL nlp_hit_entry: got %h/%b/%h want 8/1/1b", fetch_response_PC_o,
                             fetch_NLP_BTB_hit_o, fetch_response_instruction_o);
                end
            end
            if (i == 5) begin
                compared++;
                if (fetch_response_PC_o !== 64'h100 || fetch_NLP_BTB_hit_o !== 1'b0 ||
                    fetch_response_instruction_o !== 32'h113) begin
                    mismatched++;
                    $display("FAIL nlp_target_entry: got %h/%b/%h want 100/0/113",
                             fetch_response_PC_o, fetch_NLP_BTB_hit_o,
                             fetch_response_instruction_o);
                end
            end
            @(posedge clock);
            #1;
            nlp_hit_i = (i == 1);
        end
        fetch_request_ready_i = 1'b0;
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure;
        fetch_entry_t e;
        apply_reset();
        fetch_request_ready_i = 1'b1;
        fetch_response_ready_i = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        compared++;
        if (req_log.size() != 4) begin
            mismatched++; $display("FAIL bp_issued: got %0d want 4", req_log.size());
        end
        compared++;
        if (fetch_request_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL bp_stalled: got %b want 0", fetch_request_valid_o);
        end
        compared++;
        if (fetch_response_valid_o !== 1'b1 || fetch_response_PC_o !== 64'h0) begin
            mismatched++;
            $display("FAIL bp_head: got %b/%h want 1/0", fetch_response_valid_o,
                     fetch_response_PC_o);
        end
        @(posedge clock);
        #1;
        fetch_response_ready_i = 1'b1;
        @(posedge clock);
        @(negedge clock);
        compared++;
        if (fetch_request_valid_o !== 1'b1 || fetch_request_PC_o !== 64'h10) begin
            mismatched++;
            $display("FAIL bp_resume: got %b/%h want 1/10", fetch_request_valid_o,
                     fetch_request_PC_o);
        end
        repeat (6) @(posedge clock);
        #1;
        fetch_request_ready_i = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        compared++;
        if (dec_q.size() < 4) begin
            mismatched++; $display("FAIL bp_drain_count: got %0d want >=4", dec_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                e = dec_q[k];
                compared++;
                if (e.pc !== 64'(4 * k) || e.instruction !== 32'(4 * k + 'h13)) begin
                    mismatched++;
                    $display("FAIL bp_drain[%0d]: got %h/%h want %h/%h", k, e.pc, e.instruction,
                             64'(4 * k), 32'(4 * k + 'h13));
                end
            end
        end
    endtask

    task automatic test_redirect;
        fetch_entry_t e;
        apply_reset();
        fetch_request_ready_i = 1'b1;
        fetch_response_ready_i = 1'b0;
        @(posedge clock);
        @(negedge clock);
        mem_en = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        fetch_request_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_PC_i = 64'h200;
        @(negedge clock);
        compared++;
        if (fetch_request_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL redir_no_req: got %b want 0", fetch_request_valid_o);
        end
        compared++;
        if (fetch_response_valid_o !== 1'b1 || fetch_response_PC_o !== 64'h0) begin
            mismatched++;
            $display("FAIL redir_buffered: got %b/%h want 1/0", fetch_response_valid_o,
                     fetch_response_PC_o);
        end
        mem_en = 1'b1;
        @(posedge clock);
        #1;
        redirect_valid_i = 1'b0;
        fetch_request_ready_i = 1'b1;
        fetch_response_ready_i = 1'b1;
        @(negedge clock);
        compared++;
        if (fetch_response_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL redir_flushed: got %b want 0", fetch_response_valid_o);
        end
        compared++;
        if (fetch_request_valid_o !== 1'b1 || fetch_request_PC_o !== 64'h200) begin
            mismatched++;
            $display("FAIL redir_pc: got %b/%h want 1/200", fetch_request_valid_o,
                     fetch_request_PC_o);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        compared++;
        if (fetch_response_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL redir_dropped: got %b want 0", fetch_response_valid_o);
        end
        repeat (3) @(posedge clock);
        #1;
        fetch_request_ready_i = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        compared++;
        if (dec_q.size() < 2) begin
            mismatched++; $display("FAIL redir_count: got %0d want >=2", dec_q.size());
        end else begin
            e = dec_q[0];
            compared++;
            if (e.pc !== 64'h200 || e.instruction !== 32'h213) begin
                mismatched++;
                $display("FAIL redir_first: got %h/%h want 200/213", e.pc, e.instruction);
            end
            e = dec_q[1];
            compared++;
            if (e.pc !== 64'h204 || e.instruction !== 32'h217) begin
                mismatched++;
                $display("FAIL redir_second: got %h/%h want 204/217", e.pc, e.instruction);
            end
        end
    endtask

    task automatic test_wrap_and_reset;
        apply_reset();
        redirect_valid_i = 1'b1;
        redirect_PC_i = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clock);
        mem_en = 1'b0;
        @(posedge clock);
        #1;
        redirect_valid_i = 1'b0;
        fetch_request_ready_i = 1'b1;
        @(negedge clock);
        compared++;
        if (fetch_request_valid_o !== 1'b1 || fetch_request_PC_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            mismatched++;
            $display("FAIL wrap_start: got %b/%h want 1/fffffffffffffffc", fetch_request_valid_o,
                     fetch_request_PC_o);
        end
        @(posedge clock);
        @(negedge clock);
        compared++;
        if (fetch_request_PC_o !== 64'h0) begin
            mismatched++; $display("FAIL wrap_pc: got %h want 0", fetch_request_PC_o);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        compared++;
        if (fetch_request_valid_o !== 1'b0) begin
            mismatched++; $display("FAIL midreset_req_valid: got %b want 0", fetch_request_valid_o);
        end
        mem_en = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        compared++;
        if (fetch_response_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_resp_valid: got %b want 0", fetch_response_valid_o);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        fetch_request_ready_i = 1'b0;
        @(negedge clock);
        compared++;
        if (fetch_request_valid_o !== 1'b1 || fetch_request_PC_o !== 64'h0 ||
            fetch_response_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_state: got %b/%h/%b want 1/0/0", fetch_request_valid_o,
                     fetch_request_PC_o, fetch_response_valid_o);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        compared++;
        if (fetch_response_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL late_resp_ignored: got %b want 0", fetch_response_valid_o);
        end
        @(posedge clock);
        #1;
        fetch_request_ready_i = 1'b1;
        @(posedge clock);
        #1;
        fetch_request_ready_i = 1'b0;
        @(posedge clock);
        @(negedge clock);
        compared++;
        if (fetch_response_valid_o !== 1'b1 || fetch_response_PC_o !== 64'h0 ||
            fetch_response_instruction_o !== 32'h13) begin
            mismatched++;
            $display("FAIL refetch_after_reset: got %b/%h/%h want 1/0/13",
                     fetch_response_valid_o, fetch_response_PC_o,
                     fetch_response_instruction_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_nlp_hit();
        test_backpressure();
        test_redirect();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
